esc_rx_ctrl: RTL and testbench



---
 rtl/esc_pkg.sv | 39 +++
 rtl/esc_cmd_decode.sv | 26 ++
 rtl/esc_rx_ctrl.sv | 157 +++++++++++++++
 tb/tb_esc_rx_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/esc_pkg.sv
// Shared states, escape command codes and trigger bit indices for the escape-mode receiver.
package esc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LPDT,
    ST_ULPS,
    ST_WAIT_EXIT
  } esc_state_e;

  localparam logic [7:0] CMD_LPDT     = 8'hE1;
  localparam logic [7:0] CMD_ULPS     = 8'h1E;
  localparam logic [7:0] CMD_TRIG_RST = 8'h62;
  localparam logic [7:0] CMD_TRIG3    = 8'h5D;
  localparam logic [7:0] CMD_TRIG4    = 8'h21;
  localparam logic [7:0] CMD_TRIG5    = 8'hA0;

  localparam int NUM_TRIG     = 4;
  localparam int TRIG_RST_IDX = 0;
  localparam int TRIG3_IDX    = 1;
  localparam int TRIG4_IDX    = 2;
  localparam int TRIG5_IDX    = 3;

  // Maps an RxTriggerEsc bit position to the command byte that fires it.
  function automatic logic [7:0] trig_code(input int idx);
    logic [7:0] code;
    code = 8'h00;
    case (idx)
      TRIG_RST_IDX: code = CMD_TRIG_RST;
      TRIG3_IDX:    code = CMD_TRIG3;
      TRIG4_IDX:    code = CMD_TRIG4;
      TRIG5_IDX:    code = CMD_TRIG5;
      default:      code = 8'h00;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/esc_cmd_decode.sv
// Purely combinational classification of an escape entry command byte.
module esc_cmd_decode
  import esc_pkg::*;
#(
  parameter int CMD_W = 8
) (
  input  logic [CMD_W-1:0]    data_i,
  output logic                is_lpdt_o,
  output logic                is_ulps_o,
  output logic [NUM_TRIG-1:0] trig_o,
  output logic                invalid_o
);

  assign is_lpdt_o = (data_i == CMD_W'(CMD_LPDT));
  assign is_ulps_o = (data_i == CMD_W'(CMD_ULPS));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TRIG; gi++) begin : g_trig
      assign trig_o[gi] = (data_i == CMD_W'(trig_code(gi)));
    end
  endgenerate

  assign invalid_o = !(is_lpdt_o || is_ulps_o || (|trig_o));

endmodule

// File: rtl/esc_rx_ctrl.sv
// Escape-mode receive controller: command decode, LPDT byte delivery, ULPS/trigger flags, errors.
// Optional CMD-state byte timeout is enabled by defining ESC_CMD_TIMEOUT_EN.
module esc_rx_ctrl
  import esc_pkg::*;
#(
  parameter int CMD_W       = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                RxClkEsc,
  input  logic                Rst,
  input  logic                EscEntry,
  input  logic                EscExit,
  input  logic                DesValid,
  input  logic [CMD_W-1:0]    DesData,
  output logic                EscDeserEn,
  output logic                RxLpdtEsc,
  output logic                RxUlpsEsc,
  output logic [NUM_TRIG-1:0] RxTriggerEsc,
  output logic                RxValidEsc,
  output logic [CMD_W-1:0]    RxDataEsc,
  output logic                ErrEsc,
  output logic                ErrSyncEsc
);

  esc_state_e          state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [NUM_TRIG-1:0] trig_q, trig_d;
  logic                valid_q, valid_d;
  logic [CMD_W-1:0]    data_q, data_d;
  logic                err_q, err_d;
  logic                err_sync_q, err_sync_d;

  logic                dec_lpdt;
  logic                dec_ulps;
  logic [NUM_TRIG-1:0] dec_trig;
  logic                dec_invalid;

  esc_cmd_decode #(
    .CMD_W (CMD_W)
  ) u_cmd_decode (
    .data_i    (DesData),
    .is_lpdt_o (dec_lpdt),
    .is_ulps_o (dec_ulps),
    .trig_o    (dec_trig),
    .invalid_o (dec_invalid)
  );

  // Mode outputs follow the state register so they drop on the same edge that returns to IDLE.
  assign EscDeserEn   = (state_q == ST_CMD) || (state_q == ST_LPDT);
  assign RxLpdtEsc    = (state_q == ST_LPDT);
  assign RxUlpsEsc    = (state_q == ST_ULPS);
  assign RxTriggerEsc = trig_q;
  assign RxValidEsc   = valid_q;
  assign RxDataEsc    = data_q;
  assign ErrEsc       = err_q;
  assign ErrSyncEsc   = err_sync_q;

  assign bit_cnt_d = (!EscDeserEn || DesValid) ? 3'd0 : bit_cnt_q + 3'd1;

`ifdef ESC_CMD_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_ff @(posedge RxClkEsc) begin
    if (Rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    trig_d     = '0;
    valid_d    = 1'b0;
    data_d     = data_q;
    err_d      = 1'b0;
    err_sync_d = 1'b0;
`ifdef ESC_CMD_TIMEOUT_EN
    tmo_cnt_d  = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (EscEntry) begin
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (EscExit) begin
          state_d = ST_IDLE;
        end else if (DesValid) begin
          if (dec_lpdt) begin
            state_d = ST_LPDT;
          end else if (dec_ulps) begin
            state_d = ST_ULPS;
          end else if (dec_invalid) begin
            err_d   = 1'b1;
            state_d = ST_WAIT_EXIT;
          end else begin
            trig_d  = dec_trig;
            state_d = ST_WAIT_EXIT;
          end
        end
`ifdef ESC_CMD_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_WAIT_EXIT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      ST_LPDT: begin
        // A byte arriving with the exit is incomplete as far as the link is concerned.
        if (EscExit) begin
          state_d    = ST_IDLE;
          err_sync_d = DesValid || (bit_cnt_q != 3'd0);
        end else if (DesValid) begin
          valid_d = 1'b1;
          data_d  = DesData;
        end
      end
      ST_ULPS, ST_WAIT_EXIT: begin
        if (EscExit) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge RxClkEsc) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      trig_q     <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
      err_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      trig_q     <= trig_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      err_q      <= err_d;
      err_sync_q <= err_sync_d;
    end
  end

endmodule

// File: tb/tb_esc_rx_ctrl.sv
// Directed bench for esc_rx_ctrl; the timeout case runs only when ESC_CMD_TIMEOUT_EN is defined.
module tb_esc_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       entry;
  logic       esc_exit;
  logic       des_valid;
  logic [7:0] des_data;
  logic       deser_en;
  logic       lpdt;
  logic       ulps;
  logic [3:0] trig;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       err;
  logic       err_sync;

  int checks = 0;
  int errors = 0;

  esc_rx_ctrl #(
    .CMD_W       (8),
    .TIMEOUT_CYC (64)
  ) dut (
    .RxClkEsc     (clk),
    .Rst          (rst),
    .EscEntry     (entry),
    .EscExit      (esc_exit),
    .DesValid     (des_valid),
    .DesData      (des_data),
    .EscDeserEn   (deser_en),
    .RxLpdtEsc    (lpdt),
    .RxUlpsEsc    (ulps),
    .RxTriggerEsc (trig),
    .RxValidEsc   (rx_valid),
    .RxDataEsc    (rx_data),
    .ErrEsc       (err),
    .ErrSyncEsc   (err_sync)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One rising edge with the given inputs applied; outputs are sampled 1ns after the edge.
  task automatic cyc(input logic e_in, input logic x_in, input logic v_in, input logic [7:0] d_in);
    entry     = e_in;
    esc_exit  = x_in;
    des_valid = v_in;
    des_data  = d_in;
    @(posedge clk);
    #1;
    $display("txn entry=%0b exit=%0b valid=%0b data=%02h -> en=%0b lpdt=%0b ulps=%0b trig=%04b rv=%0b rd=%02h err=%0b esync=%0b",
             e_in, x_in, v_in, d_in, deser_en, lpdt, ulps, trig, rx_valid, rx_data, err, err_sync);
    entry     = 1'b0;
    esc_exit  = 1'b0;
    des_valid = 1'b0;
    des_data  = 8'h00;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en"},    32'(deser_en), 0);
    check({tag, "_lpdt"},  32'(lpdt),     0);
    check({tag, "_ulps"},  32'(ulps),     0);
    check({tag, "_trig"},  32'(trig),     0);
    check({tag, "_valid"}, 32'(rx_valid), 0);
    check({tag, "_data"},  32'(rx_data),  0);
    check({tag, "_err"},   32'(err),      0);
    check({tag, "_esync"}, 32'(err_sync), 0);
  endtask

  logic [7:0] trig_bytes [3] = '{8'h5D, 8'h21, 8'hA0};
  logic [3:0] trig_exp   [3] = '{4'b0010, 4'b0100, 4'b1000};

  initial begin
    rst = 1'b1;
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    check_all_zero("reset");
    rst = 1'b0;

    // LPDT data path
    cyc(1, 0, 0, 8'h00);
    check("cmd_en", 32'(deser_en), 1);
    cyc(0, 0, 1, 8'hE1);
    check("lpdt_mode", 32'(lpdt), 1);
    check("lpdt_cmd_novalid", 32'(rx_valid), 0);
    cyc(1, 0, 1, 8'h55);
    check("lpdt_v55", 32'(rx_valid), 1);
    check("lpdt_d55", 32'(rx_data), 'h55);
    check("lpdt_entry_ignored", 32'(lpdt), 1);
    cyc(0, 0, 1, 8'hAA);
    check("lpdt_vAA", 32'(rx_valid), 1);
    check("lpdt_dAA", 32'(rx_data), 'hAA);
    cyc(0, 0, 0, 8'h00);
    check("lpdt_gap_novalid", 32'(rx_valid), 0);
    check("lpdt_hold", 32'(rx_data), 'hAA);
    cyc(0, 0, 1, 8'h3C);
    check("lpdt_d3C", 32'(rx_data), 'h3C);
    cyc(0, 1, 0, 8'h00);
    check("lpdt_exit_mode", 32'(lpdt), 0);
    check("lpdt_exit_en", 32'(deser_en), 0);
    check("lpdt_exit_nosync", 32'(err_sync), 0);
    check("lpdt_exit_noerr", 32'(err), 0);

    // ULPS
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h1E);
    check("ulps_mode", 32'(ulps), 1);
    check("ulps_en", 32'(deser_en), 0);
    cyc(0, 0, 1, 8'hE1);
    cyc(0, 0, 0, 8'h00);
    check("ulps_hold", 32'(ulps), 1);
    check("ulps_nolpdt", 32'(lpdt), 0);
    cyc(0, 1, 0, 8'h00);
    check("ulps_exit", 32'(ulps), 0);

    // Reset trigger, extra bytes ignored
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h62);
    check("trig_rst", 32'(trig), 'b0001);
    check("trig_wait_en", 32'(deser_en), 0);
    cyc(0, 0, 0, 8'h00);
    check("trig_rst_once", 32'(trig), 0);
    cyc(0, 0, 1, 8'hE1);
    check("trig_extra_trig", 32'(trig), 0);
    check("trig_extra_lpdt", 32'(lpdt), 0);
    check("trig_extra_valid", 32'(rx_valid), 0);
    cyc(0, 1, 0, 8'h00);

    // Remaining triggers
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 8'h00);
      cyc(0, 0, 1, trig_bytes[i]);
      check($sformatf("trig_%02h", trig_bytes[i]), 32'(trig), 32'(trig_exp[i]));
      cyc(0, 1, 0, 8'h00);
      check($sformatf("trig_%02h_clr", trig_bytes[i]), 32'(trig), 0);
    end

    // Bad command
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h33);
    check("bad_err", 32'(err), 1);
    check("bad_en", 32'(deser_en), 0);
    check("bad_trig", 32'(trig), 0);
    cyc(0, 0, 1, 8'h55);
    check("bad_err_once", 32'(err), 0);
    check("bad_novalid", 32'(rx_valid), 0);
    cyc(0, 1, 0, 8'h00);
    check("bad_exit_en", 32'(deser_en), 0);

    // Sync error: exit a few cycles after the last byte
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'hE1);
    cyc(0, 0, 1, 8'h5A);
    check("sync_d5A", 32'(rx_data), 'h5A);
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);
    check("sync_err", 32'(err_sync), 1);
    check("sync_lpdt_drop", 32'(lpdt), 0);
    cyc(0, 0, 0, 8'h00);
    check("sync_err_once", 32'(err_sync), 0);

    // Exit colliding with a byte in LPDT
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'hE1);
    cyc(0, 1, 1, 8'h77);
    check("coll_novalid", 32'(rx_valid), 0);
    check("coll_esync", 32'(err_sync), 1);
    check("coll_hold", 32'(rx_data), 'h5A);
    check("coll_lpdt", 32'(lpdt), 0);

    // Reset mid-LPDT with a byte in flight
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'hE1);
    cyc(0, 0, 1, 8'h42);
    check("rst_pre_d42", 32'(rx_data), 'h42);
    rst = 1'b1;
    cyc(0, 0, 1, 8'h99);
    check_all_zero("rst_mid");
    rst = 1'b0;

`ifdef ESC_CMD_TIMEOUT_EN
    cyc(1, 0, 0, 8'h00);
    for (int i = 0; i < 63; i++) cyc(0, 0, 0, 8'h00);
    check("tmo_pre_err", 32'(err), 0);
    check("tmo_pre_en", 32'(deser_en), 1);
    cyc(0, 0, 0, 8'h00);
    check("tmo_err", 32'(err), 1);
    check("tmo_en", 32'(deser_en), 0);
    cyc(0, 1, 0, 8'h00);
    check("tmo_err_once", 32'(err), 0);
`else
    cyc(1, 0, 0, 8'h00);
    for (int i = 0; i < 100; i++) cyc(0, 0, 0, 8'h00);
    check("notmo_err", 32'(err), 0);
    check("notmo_en", 32'(deser_en), 1);
    cyc(0, 0, 1, 8'hE1);
    check("notmo_late_lpdt", 32'(lpdt), 1);
    cyc(0, 1, 0, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
